ks_subtractor_pipe: RTL

//  Pipelined two's-complement subtractor: Diff = A - B = A + ~B + 1, using a Kogge-Stone

---
 rtl/ks_subtractor_pipe_if.sv | 30 +++
 rtl/ks_subtractor_pipe.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ks_subtractor_pipe_if.sv
// Stream interface for the pipelined Kogge-Stone subtractor.
//  slave  : DUT side   (takes in_valid/in_a/in_b/out_ready, drives in_ready and results)
//  master : driver side (mirror of slave)
//  in_valid/in_ready : operand handshake, in_a minuend, in_b subtrahend
//  out_valid/out_ready : result handshake, out_diff/out_borrow/out_ovf result fields
interface ks_subtractor_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_borrow, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow, out_ovf
  );

endinterface

// File: rtl/ks_subtractor_pipe.sv
// Pipelined two's-complement subtractor, diff = A + ~B + 1, built on a Kogge-Stone
// prefix network with one register per prefix level. Latency LEVELS+2, 1 op/cycle.
//  clk  : rising-edge clock
//  rst  : asynchronous active-high reset
//  bus  : ks_subtractor_pipe_if.slave (operand and result valid/ready streams)
// The whole pipe advances as one unit when the output register is empty or being
// drained; otherwise every stage holds. in_ready is that advance signal, combinational.
module ks_subtractor_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ks_subtractor_pipe_if.slave  bus
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  // Index 0 is the G/P generation stage, index i is prefix level i.
  logic [LEVELS:0]              v_q, v_d;
  logic [LEVELS:0]              sa_q, sa_d;
  logic [LEVELS:0]              sb_q, sb_d;
  logic [LEVELS:0][WIDTH-1:0]   g_q, g_d;
  logic [LEVELS:0][WIDTH-1:0]   po_q, po_d;
  // Group propagate is only consumed by the next level, so the last level keeps none.
  logic [LEVELS-1:0][WIDTH-1:0] p_q, p_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_diff_q, out_diff_d;
  logic             out_borrow_q, out_borrow_d;
  logic             out_ovf_q, out_ovf_d;

  logic             advance;
  logic [WIDTH-1:0] carry;

  // Global stall: a held result freezes every stage.
  assign advance      = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = advance;

  // Stage 0: bitwise generate/propagate of A + ~B, carry-in folded into bit 0.
  always_comb begin : stage0_comb
    v_d[0]  = v_q[0];
    sa_d[0] = sa_q[0];
    sb_d[0] = sb_q[0];
    g_d[0]  = g_q[0];
    p_d[0]  = p_q[0];
    po_d[0] = po_q[0];
    if (advance) begin
      v_d[0]    = bus.in_valid;
      sa_d[0]   = bus.in_a[WIDTH-1];
      sb_d[0]   = bus.in_b[WIDTH-1];
      p_d[0]    = bus.in_a ^ ~bus.in_b;
      po_d[0]   = bus.in_a ^ ~bus.in_b;
      g_d[0]    = bus.in_a & ~bus.in_b;
      g_d[0][0] = g_d[0][0] | p_d[0][0];
    end
  end

  // Prefix levels: level lvl merges groups 2^(lvl-1) bits apart; low bits pass through.
  always_comb begin : prefix_comb
    for (int unsigned lvl = 1; lvl <= LEVELS; lvl++) begin
      v_d[lvl]  = v_q[lvl];
      sa_d[lvl] = sa_q[lvl];
      sb_d[lvl] = sb_q[lvl];
      g_d[lvl]  = g_q[lvl];
      po_d[lvl] = po_q[lvl];
      if (advance) begin
        v_d[lvl]  = v_q[lvl-1];
        sa_d[lvl] = sa_q[lvl-1];
        sb_d[lvl] = sb_q[lvl-1];
        po_d[lvl] = po_q[lvl-1];
        g_d[lvl]  = g_q[lvl-1];
        for (int unsigned j = (32'd1 << (lvl - 32'd1)); j < WIDTH; j++) begin
          g_d[lvl][j] = g_q[lvl-1][j] |
                        (p_q[lvl-1][j] & g_q[lvl-1][j - (32'd1 << (lvl - 32'd1))]);
        end
      end
    end
    for (int unsigned lvl = 1; lvl < LEVELS; lvl++) begin
      p_d[lvl] = p_q[lvl];
      if (advance) begin
        p_d[lvl] = p_q[lvl-1];
        for (int unsigned j = (32'd1 << (lvl - 32'd1)); j < WIDTH; j++) begin
          p_d[lvl][j] = p_q[lvl-1][j] & p_q[lvl-1][j - (32'd1 << (lvl - 32'd1))];
        end
      end
    end
  end

  // After the last level g holds the carry out of every bit position.
  assign carry = g_q[LEVELS];

  // Output stage: sum bits, borrow is the inverted carry-out, signed overflow from signs.
  always_comb begin : out_comb
    out_valid_d  = out_valid_q;
    out_diff_d   = out_diff_q;
    out_borrow_d = out_borrow_q;
    out_ovf_d    = out_ovf_q;
    if (advance) begin
      out_valid_d  = v_q[LEVELS];
      out_diff_d   = po_q[LEVELS] ^ {carry[WIDTH-2:0], 1'b1};
      out_borrow_d = ~carry[WIDTH-1];
      out_ovf_d    = (sa_q[LEVELS] ^ sb_q[LEVELS]) & (out_diff_d[WIDTH-1] ^ sa_q[LEVELS]);
    end
  end

  // All pipeline and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q          <= '0;
      sa_q         <= '0;
      sb_q         <= '0;
      g_q          <= '0;
      p_q          <= '0;
      po_q         <= '0;
      out_valid_q  <= 1'b0;
      out_diff_q   <= '0;
      out_borrow_q <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      v_q          <= v_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      g_q          <= g_d;
      p_q          <= p_d;
      po_q         <= po_d;
      out_valid_q  <= out_valid_d;
      out_diff_q   <= out_diff_d;
      out_borrow_q <= out_borrow_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_diff   = out_diff_q;
  assign bus.out_borrow = out_borrow_q;
  assign bus.out_ovf    = out_ovf_q;

endmodule
